// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared register map, bit indices and FSM state type for the APB UART
//
// Purpose: constants and types shared by uart_apb_fifo_ctrl and its testbench-facing register map.
// Ports:   none (package).

package uart_ctrl_pkg;

  // Register offsets (paddr[3:0])
  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;
  localparam logic [3:0] ADDR_DIV    = 4'hC;

  // CTRL bit indices
  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_RX_EN   = 1;
  localparam int CTRL_PAR_EN  = 2;
  localparam int CTRL_IE      = 3;
  localparam int CTRL_CLR_OVR = 8;
  localparam int CTRL_CLR_FE  = 9;
  localparam int CTRL_CLR_PE  = 10;

  // STATUS bit indices
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_OVERRUN  = 5;
  localparam int ST_FRAME    = 6;
  localparam int ST_PARITY   = 7;

  // Frame state shared by the TX and RX FSMs
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous first-word-fall-through FIFO
//
// Purpose: single-clock FIFO; pop_data always shows the head entry while not empty.
//          A push and a pop in the same cycle are both honoured, including when full.
// Ports:
//   clk, rst             clock, synchronous active-high reset (empties the FIFO)
//   push, push_data      write request and data (ignored when full and not popping)
//   pop                  read request (ignored when empty)
//   pop_data             head entry
//   full, empty          occupancy flags

module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_apb_fifo_ctrl.sv
// rtl/uart_apb_fifo_ctrl.sv - APB-controlled 8N1 UART with TX/RX FIFOs and sticky error flags
//
// Purpose: host serial port on the sys_clk APB bus. Zero-wait-state APB slave, programmable
//          baud divider (bit period = DIV+1 cycles), TX/RX FSMs, sticky overrun/frame/parity flags.
// Build option: define UART_PARITY_EN to enable the even-parity bit (CTRL.PAR_EN, STATUS[7]).
// Ports:
//   sys_clk, rst                    clock, synchronous active-high reset
//   paddr, pwrite, psel, penable    APB request
//   pstrb, pwdata                   APB write strobes and data
//   prdata, pready, pslverr         APB response (combinational in the access phase)
//   tx                              serial out, idles high
//   rx                              serial in, asynchronous
//   irq                             level interrupt

module uart_apb_fifo_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 433
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [15:0] paddr,
  input  logic        pwrite,
  input  logic        psel,
  input  logic        penable,
  input  logic [3:0]  pstrb,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

`ifdef UART_PARITY_EN
  localparam bit PAR_IMPL = 1'b1;
`else
  localparam bit PAR_IMPL = 1'b0;
`endif

  // Control / status registers
  logic             tx_en, rx_en, par_en, ie;
  logic [DIV_W-1:0] div;
  logic             ovr, fe, pe;
  logic [7:0]       status;

  // FIFO interfaces
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;

  // APB decode strobes
  logic access, addr_ok, ctrl_wr, div_wr;

  // TX FSM
  uart_state_e      tx_state, tx_next;
  logic [DIV_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_par, tx_tick, tx_load;

  // RX FSM
  uart_state_e      rx_state, rx_next;
  logic [DIV_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_s1, rx_s2, rx_prev, rx_tick;
  logic             ovr_evt, fe_evt, pe_evt;

  logic unused_bits;
  assign unused_bits = ^{pwdata, pstrb};

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(sys_clk), .rst(rst), .push(tx_push), .push_data(pwdata[7:0]), .pop(tx_pop),
    .pop_data(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(sys_clk), .rst(rst), .push(rx_push), .push_data(rx_shift), .pop(rx_pop),
    .pop_data(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // ---------------- APB slave ----------------
  assign access  = psel && penable;
  assign pready  = access;
  assign addr_ok = (paddr[15:4] == 12'h000);

  assign status = {pe & PAR_IMPL, fe, ovr, tx_state != IDLE, rx_empty, rx_full, tx_empty, tx_full};
  assign irq    = ie & (~rx_empty | tx_empty | ovr | fe | pe);

  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    ctrl_wr = 1'b0;
    div_wr  = 1'b0;
    if (access) begin
      if (!addr_ok) begin
        pslverr = 1'b1;
      end else begin
        case (paddr[3:0])
          ADDR_DATA: begin
            if (pwrite) begin
              if (tx_full) pslverr = 1'b1;
              else         tx_push = 1'b1;
            end else begin
              if (rx_empty) begin
                pslverr = 1'b1;
              end else begin
                prdata = {24'h0, rx_head};
                rx_pop = 1'b1;
              end
            end
          end
          ADDR_STATUS: if (!pwrite) prdata = {24'h0, status};
          ADDR_CTRL: begin
            if (pwrite) ctrl_wr = 1'b1;
            else        prdata  = {28'h0, ie, par_en, rx_en, tx_en};
          end
          ADDR_DIV: begin
            if (pwrite) div_wr = 1'b1;
            else        prdata = 32'(div);
          end
          default: pslverr = 1'b1;
        endcase
      end
    end
  end

  // Register updates. A flag event in the same cycle as its clear wins, so no error is lost.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tx_en  <= 1'b0;
      rx_en  <= 1'b0;
      par_en <= 1'b0;
      ie     <= 1'b0;
      div    <= DIV_W'(DEFAULT_DIV);
      ovr    <= 1'b0;
      fe     <= 1'b0;
      pe     <= 1'b0;
    end else begin
      if (ctrl_wr && pstrb[0]) begin
        tx_en  <= pwdata[CTRL_TX_EN];
        rx_en  <= pwdata[CTRL_RX_EN];
        par_en <= PAR_IMPL & pwdata[CTRL_PAR_EN];
        ie     <= pwdata[CTRL_IE];
      end
      if (ctrl_wr && pstrb[1]) begin
        if (pwdata[CTRL_CLR_OVR]) ovr <= 1'b0;
        if (pwdata[CTRL_CLR_FE])  fe  <= 1'b0;
        if (pwdata[CTRL_CLR_PE])  pe  <= 1'b0;
      end
      if (div_wr) begin
        for (int i = 0; i < DIV_W; i++) begin
          if (pstrb[i/8]) div[i] <= pwdata[i];
        end
      end
      if (ovr_evt) ovr <= 1'b1;
      if (fe_evt)  fe  <= 1'b1;
      if (pe_evt)  pe  <= 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  assign tx_tick = (tx_cnt == '0);
  // A new frame is loaded from idle, or straight from the end of STOP for back-to-back frames.
  assign tx_load = tx_en && !tx_empty && (tx_state == IDLE || (tx_state == STOP && tx_tick));
  assign tx_pop  = tx_load;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_next;
      // Idle keeps the counter primed so a new DIV is picked up at the next reload.
      if (tx_state == IDLE || tx_tick) tx_cnt <= div;
      else                             tx_cnt <= tx_cnt - DIV_W'(1);
      if (tx_load) begin
        tx_shift <= tx_head;
        tx_par   <= ^tx_head;
        tx_bit   <= '0;
      end else if (tx_state == DATA && tx_tick) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:    if (tx_load) tx_next = START;
      START:   if (tx_tick) tx_next = DATA;
      DATA:    if (tx_tick && tx_bit == 3'd7) tx_next = par_en ? PARITY : STOP;
      PARITY:  if (tx_tick) tx_next = STOP;
      STOP:    if (tx_tick) tx_next = tx_load ? START : IDLE;
      default: tx_next = IDLE;
    endcase
  end

  always_comb begin
    case (tx_state)
      START:   tx = 1'b0;
      DATA:    tx = tx_shift[0];
      PARITY:  tx = tx_par;
      default: tx = 1'b1;
    endcase
  end

  // ---------------- RX FSM ----------------
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_tick = (rx_cnt == '0);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      // Half-period load in idle places the START sample, and every later one, at mid-bit.
      if (rx_state == IDLE) rx_cnt <= div >> 1;
      else if (rx_tick)     rx_cnt <= div;
      else                  rx_cnt <= rx_cnt - DIV_W'(1);
      if (rx_state == IDLE) begin
        rx_bit <= '0;
      end else if (rx_state == DATA && rx_tick) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:    if (rx_en && rx_prev && !rx_s2) rx_next = START;
      START:   if (rx_tick) rx_next = rx_s2 ? IDLE : DATA;
      DATA:    if (rx_tick && rx_bit == 3'd7) rx_next = par_en ? PARITY : STOP;
      PARITY:  if (rx_tick) rx_next = STOP;
      STOP:    if (rx_tick) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

  always_comb begin
    rx_push = 1'b0;
    ovr_evt = 1'b0;
    fe_evt  = 1'b0;
    pe_evt  = 1'b0;
    if (rx_tick) begin
      if (rx_state == PARITY) pe_evt = (rx_s2 != ^rx_shift);
      if (rx_state == STOP) begin
        if (!rx_s2)       fe_evt  = 1'b1;
        else if (rx_full) ovr_evt = 1'b1;
        else              rx_push = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_apb_fifo_ctrl.sv
// tb/tb_uart_apb_fifo_ctrl.sv - randomized self-checking bench for uart_apb_fifo_ctrl

module tb_uart_apb_fifo_ctrl;

  localparam int FIFO_DEPTH  = 16;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 433;
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] paddr;
  logic        pwrite, psel, penable;
  logic [3:0]  pstrb;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, tx, irq;
  logic        rx_drv;
  logic        loop;
  logic        rx_line;

  assign rx_line = loop ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_apb_fifo_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .sys_clk(clk), .rst(rst), .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tx(tx), .rx(rx_line), .irq(irq)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] m_div;
  logic [3:0]  m_ctrl;
  bit          m_ovr, m_fe, m_pe;
  logic [7:0]  m_rxq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int txn, input bit busy);
    logic [7:0] s;
    s[0] = (txn == FIFO_DEPTH);
    s[1] = (txn == 0);
    s[2] = (m_rxq.size() == FIFO_DEPTH);
    s[3] = (m_rxq.size() == 0);
    s[4] = busy;
    s[5] = m_ovr;
    s[6] = m_fe;
    s[7] = m_pe & PAR;
    return {24'h0, s};
  endfunction

  task automatic apb(input bit wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    #1;
    check("setup_pready", pready, 0);
    check("setup_prdata", prdata, 0);
    @(negedge clk);
    penable = 1'b1;
    #1;
    check("pready", pready, 1);
    rd  = prdata;
    err = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic reg_wr(input logic [15:0] a, input logic [31:0] d, output logic err);
    logic [31:0] dummy;
    apb(1'b1, a, d, 4'hF, dummy, err);
  endtask

  task automatic reg_rd(input logic [15:0] a, output logic [31:0] d, output logic err);
    apb(1'b0, a, 32'h0, 4'h0, d, err);
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] st;
    logic e;
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      reg_rd(16'h4, st, e);
      if (!st[4] && st[1]) done = 1;
    end
    check("tx_idle_timeout", done, 1);
    repeat (4 * (int'(m_div) + 1) + 8) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb, input int per);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (per) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * per) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, v;
    logic        er;
    logic [15:0] a;
    logic [3:0]  s;
    logic [7:0]  b;
    logic [9:0]  f;
    logic [7:0]  bytes[$];
    int          per, k;
    bit          found;
    int          tx_divs[4];

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    rx_drv = 1'b1; loop = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_irq", irq, 0);
    check("rst_prdata", prdata, 0);
    check("rst_pready", pready, 0);
    check("rst_pslverr", pslverr, 0);
    rst = 1'b0;
    m_div = 16'(DEFAULT_DIV); m_ctrl = 4'h0; m_ovr = 0; m_fe = 0; m_pe = 0;

    reg_rd(16'h4, rd, er); check("rst_status", rd, exp_status(0, 0));
    reg_rd(16'h8, rd, er); check("rst_ctrl", rd, 0);
    reg_rd(16'hC, rd, er); check("rst_div", rd, {16'h0, m_div});

    // Randomized DIV writes with byte strobes
    repeat (8) begin
      v = $urandom;
      s = 4'($urandom_range(0, 15));
      apb(1'b1, 16'hC, v, s, rd, er);
      check("div_wr_err", er, 0);
      for (int i = 0; i < 2; i++) if (s[i]) m_div[i*8 +: 8] = v[i*8 +: 8];
      reg_rd(16'hC, rd, er);
      check("div_rd", rd, {16'h0, m_div});
    end

    // Randomized CTRL writes; FIFOs empty so irq follows IE through tx_empty
    repeat (6) begin
      v = $urandom & 32'hF;
      reg_wr(16'h8, v, er);
      m_ctrl = v[3:0] & (PAR ? 4'hF : 4'hB);
      reg_rd(16'h8, rd, er);
      check("ctrl_rd", rd, {28'h0, m_ctrl});
      check("irq_ie", irq, m_ctrl[3]);
    end
    reg_wr(16'h8, 32'h0, er);
    m_ctrl = 4'h0;

    // Unmapped addresses: error, zero data, no side effects
    repeat (8) begin
      a = 16'($urandom);
      if (a[15:4] == 12'h0 && a[1:0] == 2'b00) a[4] = 1'b1;
      apb(1'($urandom_range(0, 1)), a, $urandom, 4'hF, rd, er);
      check("unmapped_err", er, 1);
      check("unmapped_data", rd, 0);
    end
    reg_rd(16'h8, rd, er); check("ctrl_after_unmapped", rd, {28'h0, m_ctrl});
    reg_rd(16'hC, rd, er); check("div_after_unmapped", rd, {16'h0, m_div});
    reg_rd(16'h4, rd, er); check("status_after_unmapped", rd, exp_status(0, 0));
    reg_wr(16'h4, 32'hFF, er); check("status_wr_err", er, 0);
    reg_rd(16'h4, rd, er); check("status_ro", rd, exp_status(0, 0));

    // TX waveform: one frame per divider, sampled every cycle
    tx_divs = '{3, 3, 0, 1};
    reg_wr(16'h8, 32'h1, er); m_ctrl = 4'h1;
    for (int t = 0; t < 4; t++) begin
      m_div = 16'(tx_divs[t]);
      reg_wr(16'hC, {16'h0, m_div}, er);
      b = (t == 0) ? 8'hA5 : 8'($urandom);
      f = {1'b1, b, 1'b0};
      per = tx_divs[t] + 1;
      reg_wr(16'h0, {24'h0, b}, er);
      check("tx_push_err", er, 0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        if (tx === 1'b0) found = 1;
        else @(negedge clk);
      end
      check("tx_start_seen", found, 1);
      for (k = 0; k < 10 * per; k++) begin
        check("tx_bit", tx, f[k / per]);
        @(negedge clk);
      end
      check("tx_idle_after", tx, 1);
      reg_rd(16'h4, rd, er);
      check("tx_status_after", rd, exp_status(0, 0));
    end

    // Loopback tx->rx
    loop = 1'b1;
    m_div = 16'd7;
    reg_wr(16'hC, 32'd7, er);
    reg_wr(16'h8, 32'h3, er); m_ctrl = 4'h3;
    bytes = '{8'h00, 8'hFF, 8'h3C};
    repeat (3) bytes.push_back(8'($urandom));
    foreach (bytes[i]) begin
      reg_wr(16'h0, {24'h0, bytes[i]}, er);
      check("lb_push_err", er, 0);
      m_rxq.push_back(bytes[i]);
    end
    wait_idle(400);
    reg_rd(16'h4, rd, er); check("lb_status", rd, exp_status(0, 0));
    while (m_rxq.size() > 0) begin
      reg_rd(16'h0, rd, er);
      check("lb_data", rd, {24'h0, m_rxq.pop_front()});
      check("lb_err", er, 0);
    end
    reg_rd(16'h0, rd, er);
    check("rx_empty_err", er, 1);
    check("rx_empty_data", rd, 0);

    // TX FIFO overflow, then exactly FIFO_DEPTH frames fill the RX FIFO
    m_div = 16'd3;
    reg_wr(16'hC, 32'd3, er);
    reg_wr(16'h8, 32'h2, er); m_ctrl = 4'h2;
    bytes = {};
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      b = 8'($urandom);
      reg_wr(16'h0, {24'h0, b}, er);
      check("tx_fill_err", er, (i >= FIFO_DEPTH) ? 1 : 0);
      if (i < FIFO_DEPTH) bytes.push_back(b);
    end
    reg_rd(16'h4, rd, er); check("tx_full_status", rd, exp_status(FIFO_DEPTH, 0));
    reg_wr(16'h8, 32'h3, er); m_ctrl = 4'h3;
    wait_idle(600);
    foreach (bytes[i]) m_rxq.push_back(bytes[i]);
    reg_rd(16'h4, rd, er); check("rx_full_status", rd, exp_status(0, 0));

    // One more frame into the full RX FIFO
    reg_wr(16'h0, {24'h0, 8'($urandom)}, er);
    wait_idle(200);
    m_ovr = 1;
    reg_rd(16'h4, rd, er); check("overrun_status", rd, exp_status(0, 0));
    while (m_rxq.size() > 0) begin
      reg_rd(16'h0, rd, er);
      check("ovr_fifo_data", rd, {24'h0, m_rxq.pop_front()});
    end
    reg_rd(16'h0, rd, er); check("ovr_drain_err", er, 1);
    reg_rd(16'h10, rd, er); check("addr_0x10_err", er, 1);
    reg_wr(16'h8, 32'h103, er); m_ovr = 0;
    reg_rd(16'h4, rd, er); check("ovr_cleared", rd, exp_status(0, 0));

    // Driven rx: frame error, glitch rejection, valid frames, irq
    loop = 1'b0;
    m_div = 16'd7;
    reg_wr(16'hC, 32'd7, er);
    reg_wr(16'h8, 32'hA, er); m_ctrl = 4'hA;
    reg_wr(16'h0, 32'h0, er);
    check("irq_quiet", irq, 0);
    send_rx(8'($urandom), 1'b0, 8);
    m_fe = 1;
    reg_rd(16'h4, rd, er); check("frame_err_status", rd, exp_status(1, 0));
    check("irq_frame_err", irq, 1);
    reg_wr(16'h8, 32'h20A, er); m_fe = 0;
    reg_rd(16'h4, rd, er); check("frame_err_cleared", rd, exp_status(1, 0));
    check("irq_cleared", irq, 0);

    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    reg_rd(16'h4, rd, er); check("glitch_status", rd, exp_status(1, 0));

    repeat (2) begin
      b = 8'($urandom);
      send_rx(b, 1'b1, 8);
      m_rxq.push_back(b);
    end
    check("irq_rx_data", irq, 1);
    while (m_rxq.size() > 0) begin
      reg_rd(16'h0, rd, er);
      check("rx_drv_data", rd, {24'h0, m_rxq.pop_front()});
    end

    // Reset in the middle of a frame of zeros
    reg_wr(16'h8, 32'h1, er);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (tx === 1'b0) found = 1;
      else @(negedge clk);
    end
    check("rst_frame_start", found, 1);
    repeat (20) @(negedge clk);
    check("tx_mid_frame", tx, 0);
    rst = 1'b1;
    @(negedge clk);
    check("tx_after_rst", tx, 1);
    rst = 1'b0;
    m_div = 16'(DEFAULT_DIV); m_ctrl = 4'h0; m_ovr = 0; m_fe = 0; m_pe = 0; m_rxq = {};
    reg_rd(16'h4, rd, er); check("rst2_status", rd, 32'h0A);
    reg_rd(16'hC, rd, er); check("rst2_div", rd, DEFAULT_DIV);
    reg_rd(16'h8, rd, er); check("rst2_ctrl", rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_apb_fifo_ctrl.md
Name: uart_apb_fifo_ctrl

Overview:
Parametrised APB-controlled UART with transmit and receive FIFOs, a programmable baud divider, and sticky error flags. It replaces the stubbed UART controller as the host-visible serial port on the sys_clk APB bus. A single clock domain is used, and the asynchronous rx pin is synchronised internally. Frame format is 8N1, with an optional even-parity mode.

Parameters:
FIFO_DEPTH, 16, entries per TX/RX FIFO; power of two, minimum 2.
DIV_W, 16, width of the baud divider register.
DEFAULT_DIV, 433, divider reset value; bit period = DIV+1 sys_clk cycles (115200 baud at 50 MHz).

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous, active-high reset
paddr  in  16  APB address; only [3:0] decoded, upper bits must be zero
pwrite  in  1  APB write
psel  in  1  APB select
penable  in  1  APB access phase
pstrb  in  4  byte strobes; a write updates only the strobed bytes
pwdata  in  32  write data
prdata  out  32  read data, valid when pready is high
pready  out  1  transfer complete
pslverr  out  1  error response
tx  out  1  serial out, idles high
rx  in  1  serial in, asynchronous
irq  out  1  level interrupt

Behaviour:
- Reset values: tx=1, irq=0, prdata=0, pready=0, pslverr=0. Both FIFOs empty, all FSMs idle, sticky flags cleared.
- CTRL resets to 0: TX_EN=0, RX_EN=0, PAR_EN=0, IE=0. DIV resets to DEFAULT_DIV.
- APB timing: zero wait states. pready=psel&penable. prdata and pslverr are combinational during the access phase and zero otherwise. Side effects occur only on the access-phase cycle.
- Register map:
  - 0x0 DATA. Write pushes pwdata[7:0] into the TX FIFO. Read returns {24'h0, RX head} and pops the RX FIFO.
  - 0x4 STATUS (read-only, write ignored): [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy, [5] overrun, [6] frame_err, [7] parity_err.
  - 0x8 CTRL: [0] TX_EN, [1] RX_EN, [2] PAR_EN, [3] IE. Writing 1 to [8], [9] or [10] clears overrun, frame_err or parity_err respectively.
  - 0xC DIV: [DIV_W-1:0].
- pslverr rules:
  - Unmapped address, or paddr[15:4]≠0: pslverr=1, no side effect.
  - DATA write while TX FIFO full: pslverr=1, data dropped.
  - DATA read while RX FIFO empty: pslverr=1, returns 0, no pop.
- TX FSM (IDLE→START→DATA→[PARITY]→STOP→IDLE):
  - Leaves IDLE when TX_EN=1 and the TX FIFO is not empty; pops the byte on the transition.
  - Each state lasts DIV+1 cycles, counted by a down-counter reloaded with DIV.
  - DATA is sent LSB first over 8 bits. STOP drives 1.
  - Back-to-back frames: STOP goes directly to START when the FIFO is non-empty, with no idle gap.
  - TX_EN cleared mid-frame: the current frame completes, then the FSM stays in IDLE.
  - tx_busy = state≠IDLE.
- RX path:
  - rx passes through a 2-flop synchroniser.
  - RX FSM (IDLE→START→DATA→[PARITY]→STOP→IDLE):
    - IDLE: a falling edge while RX_EN=1 enters START.
    - START: samples at (DIV+1)/2 cycles. If the sample is high, it is a glitch and the FSM returns to IDLE.
    - DATA, PARITY and STOP are each sampled at the mid-bit, one full period apart.
    - STOP: if the sample is 0, sets frame_err and discards the byte.
  - Otherwise the byte is pushed at the STOP sample. If the RX FIFO is full, the byte is dropped and overrun is set.
  - A push and a pop in the same cycle are both honoured; this also applies to the TX FIFO.
- Writing DIV mid-frame takes effect at the next counter reload. DIV=0 gives a 1-cycle bit period, which is legal for TX. RX requires DIV≥2.
- irq = IE & (~rx_empty | tx_empty | overrun | frame_err | parity_err).
- Synchronous reset asserted mid-frame: tx returns high the next cycle, the partially received byte is lost, and FIFOs are emptied.

Optional Feature:
UART_PARITY_EN.
- Defined: CTRL[2] PAR_EN inserts an even-parity bit after bit 7 on TX. On RX, the parity bit is checked; a mismatch sets parity_err and the byte is still pushed.
- Undefined: the PARITY states are absent, CTRL[2] reads 0 and ignores writes, and STATUS[7] reads 0.

Decomposition:
- Package uart_ctrl_pkg holds:
  - register offsets ADDR_DATA/STATUS/CTRL/DIV;
  - CTRL and STATUS bit index constants;
  - enum uart_state_e {IDLE, START, DATA, PARITY, STOP}, shared by the TX and RX FSMs.
- One sub-module, uart_sync_fifo (parameters WIDTH, DEPTH), is instantiated twice. It provides full/empty, simultaneous push/pop, and first-word-fall-through read.

Test Plan:
- DIV=3, TX_EN=1, write DATA=0xA5 → tx low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. tx_busy deasserts 40 cycles after START entry.
- Loopback tx→rx, DIV=7, both enables set, write 0x00, 0xFF, 0x3C → three DATA reads return the same bytes in order. A fourth read gives pslverr=1 and prdata=0.
- Write FIFO_DEPTH+2 bytes with TX_EN=0 → the last two writes get pslverr=1. Set TX_EN → exactly FIFO_DEPTH frames are sent.
- Drive an rx frame with stop bit 0 → frame_err=1, RX FIFO stays empty. CTRL write of 0x200 clears it.
- Fill the RX FIFO, then send one more frame → overrun=1 and the FIFO contents are unchanged. Read paddr=0x10 → pslverr=1.
- Assert rst mid-TX frame → tx=1 next cycle, STATUS=0x0A, DIV=DEFAULT_DIV.
